oled_spi_arbiter: RTL and testbench
===================================

// Module: oled_spi_arbiter
// PURPOSE
//  Shares the single SpiCtrl byte transmitter and the OLED DC line between N_REQ byte-stream requesters
//  (e.g. panel init/command sequencer, screen/character streamer, Morse text updater).
//  Round-robin between requesters; a LOCK flag keeps the grant so multi-byte command sequences
//  (set page, page number, column low, column high) go out without interleaving.
//  Owns the SPI_EN/SPI_FIN handshake and the DC setup ordering, so requesters only present byte+DC and wait for ACK.
// PARAMETERS
//  N_REQ        2     number of requesters, legal 2..4
//  TIMEOUT_CYC  4096  max cycles in WAIT for SPI_FIN; 0 = watchdog disabled
// PORTS
//  CLK       in   1          system clock
//  RST       in   1          synchronous, active-high reset
//  REQ       in   N_REQ      per-requester byte-valid; held with DATA/DC_REQ/LOCK until ACK
//  DATA      in   8*N_REQ    byte for requester i at [8i+7:8i]
//  DC_REQ    in   N_REQ      DC level for that byte (0 = command, 1 = data)
//  LOCK      in   N_REQ      1 = keep grant after this byte
//  GNT       out  N_REQ      one-hot current owner, 0 when idle
//  ACK       out  N_REQ      1-cycle pulse to owner when its byte is complete
//  SPI_EN    out  1          to SpiCtrl
//  SPI_DATA  out  8          to SpiCtrl
//  SPI_FIN   in   1          from SpiCtrl; high while done and SPI_EN high
//  DC        out  1          to panel
//  BUSY      out  1          state != IDLE
//  ERR       out  1          sticky: a SPI_FIN timeout has occurred
// BEHAVIOUR
//  Reset: all outputs 0 (GNT, ACK, SPI_EN, SPI_DATA, DC, BUSY, ERR); state IDLE; rr pointer 0; wait counter 0.
//    RST mid-transfer drops SPI_EN on the next edge. SpiCtrl shares RST.
//  States: IDLE, SETUP, WAIT, DONE.
//  IDLE: if any REQ, pick the first requesting index at or after rr_ptr (wrapping).
//    Next edge: GNT=one-hot(winner), SPI_DATA=DATA[w], DC=DC_REQ[w], lock_r=LOCK[w]; go to SETUP.
//  SETUP: next edge SPI_EN<=1, clear wait counter, go to WAIT. DC is always stable at least 1 cycle before SPI_EN rises.
//  WAIT: count cycles.
//    On SPI_FIN=1: SPI_EN<=0, ACK[w]<=1, go to DONE.
//    Timeout: if TIMEOUT_CYC!=0 and count reaches TIMEOUT_CYC-1 with no FIN, same actions and ERR<=1 (sticky).
//  DONE: ACK<=0.
//    Keep: if lock_r and REQ[w] (next byte presented this cycle), reload SPI_DATA/DC/lock_r from requester w, keep GNT, go to SETUP.
//    Release: otherwise GNT<=0, rr_ptr<=(w+1) mod N_REQ, go to IDLE.
//  Latency: REQ high in IDLE at cycle 0 -> SPI_EN high at cycle 2; SPI_FIN at cycle k -> ACK at k+1.
//    Min byte period 4 cycles + SpiCtrl time. SPI_EN is low for >=1 cycle between bytes, which SpiCtrl needs to re-arm.
//  REQ dropped while granted (before ACK) is ignored; the byte in flight completes.
//    Requesters must not change DATA/DC_REQ before ACK.
//  A locked owner that drops REQ in DONE releases the grant; LOCK on the last byte of a burst must be 0.
//  Simultaneous REQ: rr order only. A requester that just released is lowest priority for the next pick.
//  Invalid one-hot is impossible by construction; assertion in bench.
// STRUCTURE
//  oled_pkg: state encoding, DC_CMD=1'b0 / DC_DATA=1'b1, SSD1306 command bytes
//    (SET_PAGE 8'h22, COL_LO 8'h00, COL_HI 8'h10), N_REQ max.
//  Sub-module oled_rr_pick: combinational round-robin pick (REQ, rr_ptr -> one-hot, index, any). Rest is one FSM.
// TESTING
//  1 Single byte: REQ=01, DATA0=8'h22, DC_REQ0=0 -> GNT=01 at +1, SPI_EN at +2, SPI_DATA=8'h22, DC=0; FIN -> ACK0 pulse, GNT=0.
//  2 Contention: REQ=11 held, no locks -> grants alternate 0,1,0,1; each ACK goes only to the owner.
//  3 Locked burst: req1 sends 22,02,00,10 with LOCK=1,1,1,0 while req0 requests -> 4 bytes contiguous on SPI, then req0 wins.
//  4 DC ordering: req0 cmd (DC=0) then req1 data (DC=1) -> DC changes only while SPI_EN=0, >=1 cycle before SPI_EN rise.
//  5 Timeout: TIMEOUT_CYC=16, FIN held 0 -> SPI_EN low after 16 WAIT cycles, ACK pulse, ERR=1 until RST.
//  6 Reset in WAIT: RST for 1 cycle -> next edge all outputs 0, state IDLE; a new REQ is serviced normally.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: shared FSM encoding, DC levels and SSD1306 command bytes for the OLED SPI arbiter
package oled_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;
    localparam logic DC_CMD = 1'b0;
    localparam logic DC_DATA = 1'b1;
    localparam logic [7:0] SET_PAGE = 8'h22;
    localparam logic [7:0] COL_LO = 8'h00;
    localparam logic [7:0] COL_HI = 8'h10;
    localparam int N_REQ_MAX = 4;
endpackage

// File: rtl/oled_rr_pick.sv
// oled_rr_pick: combinational pick of the first requester at or after ptr, wrapping
module oled_rr_pick
    import oled_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0] masked, cand;
    for (genvar g = 0; g < N; g++) begin : g_mask
        assign masked[g] = req[g] && (IW'(g) >= ptr);
    end
    // nothing at or above ptr means the search wraps to the lowest index
    assign cand = (|masked) ? masked : req;
    assign oh = cand & (~cand + 1'b1);
    for (genvar b = 0; b < IW; b++) begin : g_idx
        logic [N-1:0] sel_b;
        for (genvar g = 0; g < N; g++) begin : g_bit
            assign sel_b[g] = 1'((g >> b) & 1);
        end
        assign idx[b] = |(oh & sel_b);
    end
    assign any = |req;
endmodule

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: round-robin sharing of one SpiCtrl byte transmitter and the OLED DC line,
// with a lock flag that keeps the grant across multi-byte command sequences
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] DATA,
    input  logic [N_REQ-1:0]   DC_REQ,
    input  logic [N_REQ-1:0]   LOCK,
    output logic [N_REQ-1:0]   GNT,
    output logic [N_REQ-1:0]   ACK,
    output logic               SPI_EN,
    output logic [7:0]         SPI_DATA,
    input  logic               SPI_FIN,
    output logic               DC,
    output logic               BUSY,
    output logic               ERR
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    state_t state, state_d;
    logic [N_REQ-1:0] gnt_d, ack_d, pick_oh;
    logic [IW-1:0] rr_ptr, rr_d, widx, widx_d, pick_idx, sel;
    logic pick_any, spi_en_d, dc_d, err_d, lock_r, lock_d, timeout, load;
    logic [7:0] spi_data_d;
    logic [CW-1:0] wcnt, wcnt_d;
    logic [7:0] data_a [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data_a[i] = DATA[8*i +: 8];
    end
    oled_rr_pick #(.N(N_REQ)) u_pick (
        .req(REQ),
        .ptr(rr_ptr),
        .oh (pick_oh),
        .idx(pick_idx),
        .any(pick_any)
    );
    assign sel = (state == S_IDLE) ? pick_idx : widx;
    assign timeout = (TIMEOUT_CYC != 0) && (int'(wcnt) == TIMEOUT_CYC - 1);
    // a fresh grant and a locked continuation both latch byte/DC/lock from the selected requester
    assign load = (state == S_IDLE && pick_any) || (state == S_DONE && lock_r && REQ[widx]);
    assign BUSY = state != S_IDLE;
    always_comb begin
        state_d    = state;
        gnt_d      = GNT;
        ack_d      = '0;
        spi_en_d   = SPI_EN;
        spi_data_d = load ? data_a[sel] : SPI_DATA;
        dc_d       = load ? DC_REQ[sel] : DC;
        lock_d     = load ? LOCK[sel] : lock_r;
        err_d      = ERR;
        rr_d       = rr_ptr;
        widx_d     = widx;
        wcnt_d     = wcnt;
        case (state)
            S_IDLE: if (pick_any) begin
                gnt_d   = pick_oh;
                widx_d  = pick_idx;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                spi_en_d = 1'b1;
                wcnt_d   = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: if (SPI_FIN || timeout) begin
                spi_en_d = 1'b0;
                ack_d    = GNT;
                err_d    = ERR | !SPI_FIN;
                state_d  = S_DONE;
            end else begin
                wcnt_d = wcnt + 1'b1;
            end
            S_DONE: if (load) begin
                state_d = S_SETUP;
            end else begin
                gnt_d   = '0;
                rr_d    = (widx == IW'(N_REQ - 1)) ? '0 : widx + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            GNT      <= '0;
            ACK      <= '0;
            SPI_EN   <= 1'b0;
            SPI_DATA <= '0;
            DC       <= 1'b0;
            ERR      <= 1'b0;
            lock_r   <= 1'b0;
            rr_ptr   <= '0;
            widx     <= '0;
            wcnt     <= '0;
        end else begin
            state    <= state_d;
            GNT      <= gnt_d;
            ACK      <= ack_d;
            SPI_EN   <= spi_en_d;
            SPI_DATA <= spi_data_d;
            DC       <= dc_d;
            ERR      <= err_d;
            lock_r   <= lock_d;
            rr_ptr   <= rr_d;
            widx     <= widx_d;
            wcnt     <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb_oled_spi_arbiter: directed checks of grant order, lock bursts, DC ordering, timeout and reset
module tb_oled_spi_arbiter;
    import oled_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [1:0] REQ = '0;
    logic [15:0] DATA = '0;
    logic [1:0] DC_REQ = '0;
    logic [1:0] LOCK = '0;
    logic [1:0] GNT, ACK;
    logic SPI_EN, SPI_FIN, DC, BUSY, ERR;
    logic [7:0] SPI_DATA;
    always #5 CLK = ~CLK;
    oled_spi_arbiter #(.N_REQ(2), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA), .DC_REQ(DC_REQ), .LOCK(LOCK),
        .GNT(GNT), .ACK(ACK), .SPI_EN(SPI_EN), .SPI_DATA(SPI_DATA), .SPI_FIN(SPI_FIN),
        .DC(DC), .BUSY(BUSY), .ERR(ERR)
    );
    // SpiCtrl stand-in: FIN rises 3 cycles after SPI_EN and holds while SPI_EN is high
    logic fin_en = 1'b1;
    logic [7:0] fcnt;
    always @(posedge CLK) begin
        if (RST || !SPI_EN) begin
            fcnt    <= '0;
            SPI_FIN <= 1'b0;
        end else if (fin_en) begin
            fcnt    <= fcnt + 8'd1;
            SPI_FIN <= fcnt >= 8'd2;
        end
    end
    always @(negedge CLK) assert ($onehot0(GNT)) else $error("GNT not one-hot: %b", GNT);
    int n_chk = 0, n_pass = 0;
    int ack_bad = 0, dc_viol = 0, en_hi = 0;
    logic prev_en = 1'b0, prev_dc = 1'b0;
    logic [9:0] q0[$], q1[$];
    logic [7:0] log_data[$];
    logic log_dc[$];
    logic [1:0] log_gnt[$];
    int log_ack[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic present();
        REQ[0] = q0.size() != 0;
        REQ[1] = q1.size() != 0;
        if (q0.size() != 0) {LOCK[0], DC_REQ[0], DATA[7:0]} = q0[0];
        if (q1.size() != 0) {LOCK[1], DC_REQ[1], DATA[15:8]} = q1[0];
    endtask
    task automatic tick();
        @(negedge CLK);
        if (SPI_EN) en_hi++;
        if (SPI_EN && !prev_en) begin
            log_data.push_back(SPI_DATA);
            log_dc.push_back(DC);
            log_gnt.push_back(GNT);
        end
        if (DC !== prev_dc && (SPI_EN || prev_en)) dc_viol++;
        if ((ACK & ~GNT) != 2'b00) ack_bad++;
        if (ACK[0]) begin
            log_ack.push_back(0);
            if (q0.size() != 0) void'(q0.pop_front());
        end
        if (ACK[1]) begin
            log_ack.push_back(1);
            if (q1.size() != 0) void'(q1.pop_front());
        end
        present();
        prev_en = SPI_EN;
        prev_dc = DC;
    endtask
    task automatic clear_logs();
        log_data.delete();
        log_dc.delete();
        log_gnt.delete();
        log_ack.delete();
        en_hi = 0;
    endtask
    task automatic run_until_idle(input string tag, input int bound);
        int c = 0;
        while ((BUSY || REQ != 2'b00) && c < bound) begin
            tick();
            c++;
        end
        check({tag, "_done"}, 32'(c < bound), 32'd1);
    endtask
    function automatic logic [31:0] dat(input int k);
        return k < log_data.size() ? 32'(log_data[k]) : 32'hdead;
    endfunction
    function automatic logic [31:0] gnt(input int k);
        return k < log_gnt.size() ? 32'(log_gnt[k]) : 32'hdead;
    endfunction
    function automatic logic [31:0] ackx(input int k);
        return k < log_ack.size() ? 32'(log_ack[k]) : 32'hdead;
    endfunction
    function automatic logic [31:0] dcx(input int k);
        return k < log_dc.size() ? 32'(log_dc[k]) : 32'hdead;
    endfunction
    initial begin
        int c;
        repeat (3) tick();
        check("rst_gnt", 32'(GNT), 32'd0);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_en", 32'(SPI_EN), 32'd0);
        check("rst_data", 32'(SPI_DATA), 32'd0);
        check("rst_dc", 32'(DC), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        RST = 1'b0;
        tick();
        // single byte from requester 0
        clear_logs();
        q0.push_back({1'b0, DC_CMD, SET_PAGE});
        present();
        tick();
        check("t1_gnt", 32'(GNT), 32'd1);
        check("t1_en_setup", 32'(SPI_EN), 32'd0);
        check("t1_data", 32'(SPI_DATA), 32'h22);
        check("t1_dc", 32'(DC), 32'd0);
        check("t1_busy", 32'(BUSY), 32'd1);
        tick();
        check("t1_en", 32'(SPI_EN), 32'd1);
        run_until_idle("t1", 40);
        check("t1_nack", 32'(log_ack.size()), 32'd1);
        check("t1_ack", ackx(0), 32'd0);
        check("t1_gnt_rel", 32'(GNT), 32'd0);
        check("t1_err", 32'(ERR), 32'd0);
        // contention, no locks: rr pointer is 1 after requester 0 released
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            q0.push_back({1'b0, DC_DATA, 8'(8'h40 + k)});
            q1.push_back({1'b0, DC_DATA, 8'(8'h50 + k)});
        end
        present();
        run_until_idle("t2", 200);
        check("t2_nbytes", 32'(log_data.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("t2_gnt", gnt(k), (k % 2 == 0) ? 32'd2 : 32'd1);
            check("t2_data", dat(k), (k % 2 == 0) ? 32'(8'h50 + k / 2) : 32'(8'h40 + k / 2));
            check("t2_ack", ackx(k), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t2_ack_owner", 32'(ack_bad), 32'd0);
        // locked 4-byte burst from requester 1 while requester 0 waits
        clear_logs();
        q1.push_back({1'b1, DC_CMD, SET_PAGE});
        q1.push_back({1'b1, DC_CMD, 8'h02});
        q1.push_back({1'b1, DC_CMD, COL_LO});
        q1.push_back({1'b0, DC_CMD, COL_HI});
        q0.push_back({1'b0, DC_DATA, 8'h55});
        present();
        run_until_idle("t3", 200);
        check("t3_nbytes", 32'(log_data.size()), 32'd5);
        check("t3_d0", dat(0), 32'h22);
        check("t3_d1", dat(1), 32'h02);
        check("t3_d2", dat(2), 32'h00);
        check("t3_d3", dat(3), 32'h10);
        check("t3_d4", dat(4), 32'h55);
        for (int k = 0; k < 4; k++) check("t3_gnt_burst", gnt(k), 32'd2);
        check("t3_gnt_after", gnt(4), 32'd1);
        // DC level follows each byte and never moves while SPI_EN is high
        clear_logs();
        q0.push_back({1'b0, DC_CMD, 8'hAE});
        q1.push_back({1'b0, DC_DATA, 8'hFF});
        present();
        run_until_idle("t4", 100);
        check("t4_d0", dat(0), 32'hFF);
        check("t4_dc0", dcx(0), 32'd1);
        check("t4_d1", dat(1), 32'hAE);
        check("t4_dc1", dcx(1), 32'd0);
        check("t4_dc_order", 32'(dc_viol), 32'd0);
        // FIN never arrives: watchdog ends the byte after 16 WAIT cycles
        clear_logs();
        fin_en = 1'b0;
        q0.push_back({1'b0, DC_DATA, 8'hA5});
        present();
        run_until_idle("t5", 100);
        check("t5_en_cycles", 32'(en_hi), 32'd16);
        check("t5_nack", 32'(log_ack.size()), 32'd1);
        check("t5_ack", ackx(0), 32'd0);
        check("t5_err", 32'(ERR), 32'd1);
        fin_en = 1'b1;
        clear_logs();
        q1.push_back({1'b0, DC_DATA, 8'h5A});
        present();
        run_until_idle("t5b", 100);
        check("t5_d_after", dat(0), 32'h5A);
        check("t5_err_sticky", 32'(ERR), 32'd1);
        // reset while waiting for FIN
        clear_logs();
        q0.push_back({1'b0, DC_CMD, 8'h3C});
        present();
        c = 0;
        while (!SPI_EN && c < 10) begin
            tick();
            c++;
        end
        check("t6_en_before", 32'(SPI_EN), 32'd1);
        RST = 1'b1;
        q0.delete();
        present();
        tick();
        check("t6_gnt", 32'(GNT), 32'd0);
        check("t6_ack", 32'(ACK), 32'd0);
        check("t6_en", 32'(SPI_EN), 32'd0);
        check("t6_data", 32'(SPI_DATA), 32'd0);
        check("t6_dc", 32'(DC), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        check("t6_err", 32'(ERR), 32'd0);
        RST = 1'b0;
        tick();
        clear_logs();
        q1.push_back({1'b0, DC_DATA, 8'h81});
        present();
        run_until_idle("t6b", 100);
        check("t6_d_new", dat(0), 32'h81);
        check("t6_gnt_new", gnt(0), 32'd2);
        check("t6_ack_new", ackx(0), 32'd1);
        check("all_dc_order", 32'(dc_viol), 32'd0);
        check("all_ack_owner", 32'(ack_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
